project_selector: RTL and testbench
===================================

Name: project_selector

Overview:
- Wishbone-controlled generator of the per-project `active` enables for the multi-project user area.
- Drives the one-hot `active` bus that gates each wrapped project's shared io/la outputs. Sits directly upstream of the project instances, replacing raw logic-analyser driving of `active`.
- Guarantees at most one project is enabled at any time.
- Inserts a guard period with all projects disabled on every switch, so shared io_out/io_oeb never see two drivers.

Parameters:
- NUM_PROJECTS, 16, number of project enables driven (max 2**ID_W).
- ID_W, 4, width of the project id field.
- GUARD_CYCLES, 8, cycles all enables are held low between projects; must be >= 1.
- BASE_ADDR, 32'h3000_0000, Wishbone base. SELECT register at BASE_ADDR+0, STATUS register at BASE_ADDR+4.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte lane selects.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address.
- wbs_ack_o  output  1  Wishbone acknowledge.
- wbs_dat_o  output  32  read data.
- active_o  output  NUM_PROJECTS  one-hot project enable, or all zero.
- switch_irq_o  output  1  one-cycle pulse when a new project becomes active.

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset wb_rst_n is asynchronous, active-low.
- Reset values: all outputs 0 (active_o, wbs_ack_o, wbs_dat_o, switch_irq_o). FSM in IDLE; target_id=0, enable=0, error=0, guard counter=0.
- Bus handshake:
  - A request is sampled at edge E when wbs_stb_i & wbs_cyc_i & !wbs_ack_o.
  - wbs_ack_o is 1 for exactly the cycle following E, then 0.
  - Back-to-back requests are therefore acked every other cycle.
  - wbs_dat_o is registered at E. It holds read data only during the ack cycle and is 0 otherwise.
- Address decode: only wbs_adr_i == BASE_ADDR or BASE_ADDR+4 decode. Any other address is still acked, reads 0, and writes are ignored.
- SELECT write:
  - Effective only if wbs_sel_i[1:0] == 2'b11; otherwise acked and ignored.
  - Fields: dat[ID_W-1:0] = id, dat[8] = enable.
  - id >= NUM_PROJECTS with enable=1: sets the sticky error bit; no other state change.
- SELECT read: {23'b0, enable, (8-ID_W)'b0, target_id}.
- STATUS read: bits[ID_W-1:0] = current running id, bit16 = busy (GUARD), bit17 = running (RUN), bit24 = error.
- STATUS write: bit24 = 1 clears error (write-1-to-clear), requires wbs_sel_i[3]. All other bits are ignored.
- FSM states:
  - IDLE: active_o = 0.
  - GUARD: active_o = 0; counter counts down.
  - RUN: active_o = 1 << running_id.
- Transitions on a legal SELECT write at edge E:
  - enable=0, from any state: go to IDLE. active_o = 0 from E.
  - enable=1, in RUN with id == running_id: no state change, no irq.
  - enable=1, any other case (including a write during GUARD): target_id = id, go to GUARD, counter = GUARD_CYCLES, active_o = 0 from E. A write during GUARD restarts the full guard period.
- GUARD timing:
  - Counter decrements once per cycle.
  - When the counter reaches 1, the next edge enters RUN with running_id = target_id.
  - At that edge active_o becomes one-hot and switch_irq_o = 1 for one cycle.
  - Net effect: active_o is all zero for exactly GUARD_CYCLES cycles after E. The new bit asserts at E+GUARD_CYCLES.
- Invariant: popcount(active_o) <= 1 on every cycle, including across the edge where the switch happens.
- Reset mid-operation (GUARD or RUN): active_o drops to 0 immediately (asynchronously), FSM returns to IDLE, and an in-flight ack is cancelled.

Test Plan:
- Reset release, no bus traffic -> active_o=0, switch_irq_o=0, STATUS reads 0.
- Write SELECT 0x105 at edge E -> ack at E+1; active_o=0 through E+7; active_o=16'h0020 from E+8; switch_irq_o single pulse at E+8; STATUS=0x0002_0005.
- While running id 5, write 0x10A -> active_o=0 immediately for 8 cycles, then 16'h0400. Check popcount<=1 every cycle.
- Write 0x103, then 3 cycles later write 0x107 -> guard restarts; active_o=16'h0080 exactly 8 cycles after the second write; bit 3 never asserts.
- Write 0x110 with NUM_PROJECTS=16 -> STATUS bit24=1, active_o unchanged. Write STATUS with 0x0100_0000 and sel=4'b1000 -> bit24 clears. A write with sel=4'b0001 is ignored but still acked.
- Assert wb_rst_n=0 mid-GUARD and again mid-RUN -> active_o=0 asynchronously; after release the FSM is IDLE. Read of an unmapped address -> ack, data 0.

Source files
------------

// File: rtl/project_selector.sv
// project_selector: Wishbone-controlled generator of the one-hot project
// enables for the multi-project user area. At most one enable is ever high,
// and every switch passes through a guard window with all enables low so the
// shared io_out/io_oeb pads never see two drivers.
module project_selector #(
    parameter int          NUM_PROJECTS = 16,
    parameter int          ID_W         = 4,
    parameter int          GUARD_CYCLES = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic                    switch_irq_o
);

    localparam int          CNT_W       = $clog2(GUARD_CYCLES + 1);
    localparam logic [31:0] SELECT_ADDR = BASE_ADDR;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_RUN
    } state_e;

    state_e                  state_q;
    logic [ID_W-1:0]         target_id_q;
    logic [ID_W-1:0]         running_id_q;
    logic                    enable_q;
    logic                    error_q;
    logic [CNT_W-1:0]        guard_cnt_q;
    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [31:0]             dat_d;
    logic [NUM_PROJECTS-1:0] active_q;
    logic                    irq_q;

    // Bus request decode
    logic            req;
    logic            hit_select;
    logic            hit_status;
    logic            select_wr;
    logic            error_clr;
    logic [ID_W-1:0] wr_id;
    logic            wr_en;
    logic            wr_id_bad;
    logic            same_as_running;

    // A new request is only taken while no ack is outstanding, so the
    // handshake naturally alternates request / ack.
    assign req        = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign hit_select = (wbs_adr_i == SELECT_ADDR);
    assign hit_status = (wbs_adr_i == STATUS_ADDR);
    assign select_wr  = req & wbs_we_i & hit_select & (wbs_sel_i[1:0] == 2'b11);
    assign error_clr  = req & wbs_we_i & hit_status & wbs_sel_i[3] & wbs_dat_i[24];

    assign wr_id      = wbs_dat_i[ID_W-1:0];
    assign wr_en      = wbs_dat_i[8];
    // The whole low byte is range-checked so ids that overflow the id field
    // are rejected rather than silently aliased onto a legal project.
    assign wr_id_bad  = ({1'b0, wbs_dat_i[7:0]} >= 9'(NUM_PROJECTS));
    assign same_as_running = (state_q == ST_RUN) && (wr_id == running_id_q);

    // Data bits with no meaning in either register
    logic unused_bits;
    assign unused_bits = &{1'b0, wbs_sel_i[2], wbs_dat_i[31:25], wbs_dat_i[23:9]};

    // Read data mux; zero unless a read of a mapped register is being taken
    always_comb begin
        // NOTE: default first so every path assigns dat_d and no latch is inferred.
        dat_d = '0;
        if (req && !wbs_we_i) begin
            if (hit_select) begin
                dat_d[8]        = enable_q;
                dat_d[ID_W-1:0] = target_id_q;
            end else if (hit_status) begin
                dat_d[ID_W-1:0] = (state_q == ST_RUN) ? running_id_q : '0;
                dat_d[16]       = (state_q == ST_GUARD);
                dat_d[17]       = (state_q == ST_RUN);
                dat_d[24]       = error_q;
            end
        end
    end

    // Bus response registers: single-cycle ack and data valid only with ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            ack_q <= req;
            dat_q <= dat_d;
        end
    end

    // Project selection FSM with registered enable and irq outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= ST_IDLE;
            target_id_q  <= '0;
            running_id_q <= '0;
            enable_q     <= 1'b0;
            error_q      <= 1'b0;
            guard_cnt_q  <= '0;
            active_q     <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (error_clr) begin
                error_q <= 1'b0;
            end

            if (select_wr && wr_en && wr_id_bad) begin
                error_q <= 1'b1;
            end else if (select_wr && !wr_en) begin
                state_q     <= ST_IDLE;
                enable_q    <= 1'b0;
                guard_cnt_q <= '0;
                active_q    <= '0;
            end else if (select_wr && !same_as_running) begin
                // Any new target, including one written mid-guard, restarts
                // the full guard window with every enable low.
                state_q     <= ST_GUARD;
                target_id_q <= wr_id;
                enable_q    <= 1'b1;
                guard_cnt_q <= CNT_W'(GUARD_CYCLES);
                active_q    <= '0;
            end else if (state_q == ST_GUARD) begin
                if (guard_cnt_q == CNT_W'(1)) begin
                    state_q      <= ST_RUN;
                    running_id_q <= target_id_q;
                    guard_cnt_q  <= '0;
                    active_q     <= NUM_PROJECTS'(1) << target_id_q;
                    irq_q        <= 1'b1;
                end else begin
                    guard_cnt_q <= guard_cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign active_o     = active_q;
    assign switch_irq_o = irq_q;

endmodule

// File: tb/tb_project_selector.sv
// Directed testbench for project_selector: bus handshake, guard timing,
// guard restart, error handling, address decode and asynchronous reset.
module tb_project_selector;

    localparam int          GUARD = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] SEL_A = BASE;
    localparam logic [31:0] STA_A = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_in, adr;
    logic        ack;
    logic [31:0] dat_out;
    logic [15:0] active;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    project_selector #(
        .NUM_PROJECTS (16),
        .ID_W         (4),
        .GUARD_CYCLES (GUARD),
        .BASE_ADDR    (BASE)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (dat_in),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_out),
        .active_o     (active),
        .switch_irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // At most one enable on every cycle
    always @(negedge clk) begin
        check("onehot", 32'($countones(active) <= 1), 32'd1);
    end

    // One bus access; returns at the negedge of the ack cycle
    task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, output logic [31:0] rdata);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; dat_in = d; adr = a;
        @(posedge clk);
        @(negedge clk);
        check("ack", 32'(ack), 32'd1);
        rdata = dat_out;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_in = '0; adr = '0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        wb_access(a, d, s, 1'b1, unused_rd);
    endtask

    task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(a, 32'h0, 4'hF, 1'b0, rd);
        check(tag, rd, exp);
    endtask

    // Called at the negedge right after the write edge E: expects enables low
    // through E+GUARD-1 and the new one-hot value with a single irq at E+GUARD.
    task automatic expect_switch(input logic [15:0] exp_active);
        check("guard_low_at_E", 32'(active), 32'h0);
        for (int k = 1; k < GUARD; k++) begin
            @(negedge clk);
            check("guard_low", 32'(active), 32'h0);
            check("guard_irq", 32'(irq), 32'd0);
        end
        @(negedge clk);
        check("switch_active", 32'(active), 32'(exp_active));
        check("switch_irq", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_end", 32'(irq), 32'd0);
        check("run_hold", 32'(active), 32'(exp_active));
    endtask

    initial begin
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_in = '0; adr = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_active", 32'(active), 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_out, 32'h0);
        wb_read_check("rst_status", STA_A, 32'h0);
        @(negedge clk);
        check("ack_drop", 32'(ack), 32'd0);
        check("dat_drop", dat_out, 32'h0);

        // First selection: project 5
        wb_write(SEL_A, 32'h105, 4'b0011);
        expect_switch(16'h0020);
        wb_read_check("status_run5", STA_A, 32'h0002_0005);
        wb_read_check("select_rd5", SEL_A, 32'h0000_0105);

        // Re-selecting the running project changes nothing
        wb_write(SEL_A, 32'h105, 4'hF);
        repeat (GUARD + 1) @(negedge clk);
        check("same_id_active", 32'(active), 32'h0020);

        // Switch while running
        wb_write(SEL_A, 32'h10A, 4'hF);
        expect_switch(16'h0400);

        // Guard restart: 0x103 then 0x107 three cycles later
        wb_write(SEL_A, 32'h103, 4'hF);
        check("restart_low0", 32'(active), 32'h0);
        @(negedge clk);
        check("restart_low1", 32'(active), 32'h0);
        wb_write(SEL_A, 32'h107, 4'hF);
        expect_switch(16'h0080);
        wb_read_check("status_run7", STA_A, 32'h0002_0007);

        // Out-of-range id sets error and leaves the running project alone
        wb_write(SEL_A, 32'h110, 4'hF);
        wb_read_check("status_err", STA_A, 32'h0102_0007);
        check("err_active", 32'(active), 32'h0080);
        // Clear without the top byte lane is ignored
        wb_write(STA_A, 32'h0100_0000, 4'b0111);
        wb_read_check("status_err_kept", STA_A, 32'h0102_0007);
        wb_write(STA_A, 32'h0100_0000, 4'b1000);
        wb_read_check("status_err_clr", STA_A, 32'h0002_0007);

        // Partial byte-lane SELECT write is acked but ignored
        wb_write(SEL_A, 32'h102, 4'b0001);
        repeat (GUARD + 1) @(negedge clk);
        check("sel_partial_active", 32'(active), 32'h0080);
        wb_read_check("sel_partial_rd", SEL_A, 32'h0000_0107);

        // Unmapped address: acked, reads 0, writes ignored
        wb_read_check("unmapped_rd", BASE + 32'd8, 32'h0);
        wb_write(BASE + 32'd8, 32'h101, 4'hF);
        repeat (GUARD + 1) @(negedge clk);
        check("unmapped_wr_active", 32'(active), 32'h0080);

        // Disable: enables drop from the write edge
        wb_write(SEL_A, 32'h000, 4'hF);
        check("disable_active", 32'(active), 32'h0);
        wb_read_check("disable_rd", SEL_A, 32'h0000_0007);
        begin
            logic [31:0] st;
            wb_access(STA_A, 32'h0, 4'hF, 1'b0, st);
            check("disable_state", st & 32'h0003_0000, 32'h0);
        end

        // Reset mid-GUARD with an ack in flight
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; dat_in = 32'h101; adr = SEL_A;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_guard_ack", 32'(ack), 32'd0);
        check("rst_guard_active", 32'(active), 32'h0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_in = '0; adr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (GUARD + 2) @(negedge clk);
        check("rst_guard_idle", 32'(active), 32'h0);
        wb_read_check("rst_guard_status", STA_A, 32'h0);

        // Reset mid-RUN
        wb_write(SEL_A, 32'h10F, 4'hF);
        expect_switch(16'h8000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_run_active", 32'(active), 32'h0);
        check("rst_run_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read_check("rst_run_status", STA_A, 32'h0);
        wb_read_check("rst_run_select", SEL_A, 32'h0);
        check("rst_run_idle", 32'(active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
